// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and defaults for the operand-forwarding / hazard unit.
// Forwarding-source enum and default data-path dimensions.
package hazard_forward_unit_pkg;

    localparam int DEF_XLEN = 64;
    localparam int DEF_NREG = 32;

    typedef enum logic [2:0] {
        FWD_ID,
        FWD_EX,
        FWD_MEM,
        FWD_MDU,
        FWD_WB
    } fwd_sel_e;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Per-source operand selection and hazard detection; one instance per source register.
// Priority: EX (result ready) > MEM > MDU completion > WB > register file.
module hazard_forward_unit_fwd_select
    import hazard_forward_unit_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int RW   = 5
) (
    input  logic [RW-1:0]   rs,
    input  logic            use_rs,
    input  logic [XLEN-1:0] id_op,
    input  logic            sb_pending_rs,
    input  logic            ex_valid,
    input  logic            ex_wen,
    input  logic            ex_long,
    input  logic [RW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_res,
    input  logic            mem_valid,
    input  logic            mem_wen,
    input  logic [RW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_res,
    input  logic            wb_valid,
    input  logic            wb_wen,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_res,
    input  logic            mdu_done,
    input  logic [RW-1:0]   mdu_rd,
    input  logic [XLEN-1:0] mdu_res,
    output logic [XLEN-1:0] op_fwd,
    output logic            hazard
);

    logic     live;
    logic     ex_hit;
    logic     mem_hit;
    logic     mdu_hit;
    logic     wb_hit;
    fwd_sel_e sel;

    // x0 and immediate operands never match any producer.
    assign live    = use_rs && (rs != '0);
    assign ex_hit  = live && ex_valid  && ex_wen  && (ex_rd  == rs);
    assign mem_hit = live && mem_valid && mem_wen && (mem_rd == rs);
    assign wb_hit  = live && wb_valid  && wb_wen  && (wb_rd  == rs);
    assign mdu_hit = live && mdu_done  && (mdu_rd == rs);

    always_comb begin
        // NOTE: default assigned first so every path drives sel; no latch is inferred.
        sel = FWD_ID;
        if (ex_hit && !ex_long) sel = FWD_EX;
        else if (mem_hit)       sel = FWD_MEM;
        else if (mdu_hit)       sel = FWD_MDU;
        else if (wb_hit)        sel = FWD_WB;
    end

    always_comb begin
        op_fwd = id_op;
        case (sel)
            FWD_EX:  op_fwd = ex_res;
            FWD_MEM: op_fwd = mem_res;
            FWD_MDU: op_fwd = mdu_res;
            FWD_WB:  op_fwd = wb_res;
            default: op_fwd = id_op;
        endcase
    end

    // A completing MDU result resolves its own pending entry in the same cycle.
    assign hazard = (ex_hit && ex_long) || (live && sb_pending_rs && !mdu_hit);

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding, MDU scoreboard and decode-stall generation between ID and EX.
// Optional performance counters (stall_cnt, sb_busy_cnt) are enabled by HAZARD_PERF_EN.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter  int XLEN = DEF_XLEN,
    parameter  int NREG = DEF_NREG,
    localparam int RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RW-1:0]   id_rs1,
    input  logic [RW-1:0]   id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [XLEN-1:0] id_op1,
    input  logic [XLEN-1:0] id_op2,
    input  logic            ex_valid,
    input  logic            ex_wen,
    input  logic            ex_long,
    input  logic [RW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_res,
    input  logic            mem_valid,
    input  logic            mem_wen,
    input  logic [RW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_res,
    input  logic            wb_valid,
    input  logic            wb_wen,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_res,
    input  logic            mdu_issue,
    input  logic            mdu_done,
    input  logic [RW-1:0]   mdu_rd,
    input  logic [XLEN-1:0] mdu_res,
    output logic [XLEN-1:0] op1_fwd,
    output logic [XLEN-1:0] op2_fwd,
    output logic            stall,
`ifdef HAZARD_PERF_EN
    output logic [31:0]     stall_cnt,
    output logic [31:0]     sb_busy_cnt,
`endif
    output logic [NREG-1:0] sb_pending
);

    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;
    logic            hazard1;
    logic            hazard2;

    hazard_forward_unit_fwd_select #(.XLEN(XLEN), .RW(RW)) u_fwd_rs1 (
        .rs(id_rs1), .use_rs(id_use_rs1), .id_op(id_op1), .sb_pending_rs(sb_q[id_rs1]),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_long(ex_long), .ex_rd(ex_rd), .ex_res(ex_res),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_res(mem_res),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_res(wb_res),
        .mdu_done(mdu_done), .mdu_rd(mdu_rd), .mdu_res(mdu_res),
        .op_fwd(op1_fwd), .hazard(hazard1)
    );

    hazard_forward_unit_fwd_select #(.XLEN(XLEN), .RW(RW)) u_fwd_rs2 (
        .rs(id_rs2), .use_rs(id_use_rs2), .id_op(id_op2), .sb_pending_rs(sb_q[id_rs2]),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_long(ex_long), .ex_rd(ex_rd), .ex_res(ex_res),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_res(mem_res),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_res(wb_res),
        .mdu_done(mdu_done), .mdu_rd(mdu_rd), .mdu_res(mdu_res),
        .op_fwd(op2_fwd), .hazard(hazard2)
    );

    assign stall = id_valid && (hazard1 || hazard2);

    // Clear before set so a same-cycle issue to the completing index stays pending.
    always_comb begin
        sb_d = sb_q;
        if (mdu_done) sb_d[mdu_rd] = 1'b0;
        if (mdu_issue && ex_valid && (ex_rd != '0)) sb_d[ex_rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) sb_q <= '0;
        else     sb_q <= sb_d;
    end

    assign sb_pending = sb_q;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt   <= '0;
            sb_busy_cnt <= '0;
        end else begin
            if (stall)      stall_cnt   <= stall_cnt + 32'd1;
            if (|sb_q)      sb_busy_cnt <= sb_busy_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised operand-forwarding and hazard unit for the in-order integer pipeline. It supersedes the single-stage, two-source forwarding mux. It forwards from the EX, MEM and WB stages and from a multi-cycle MDU completion port, never forwards x0, and honours per-source "uses register" flags. It also keeps a registered scoreboard of outstanding MDU destinations and raises a decode stall on load-use and MDU-pending hazards. It sits between ID and EX and drives the EX operand registers and the front-end stall line.

## Interface
Parameters:
- XLEN, 64: data width.
- NREG, 32: architectural register count; RW = $clog2(NREG).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1, id_rs2  in  RW  source indices.
- id_use_rs1, id_use_rs2  in  1  source is a register (0 = immediate or unused).
- id_op1, id_op2  in  XLEN  register-file read values.
- ex_valid, ex_wen, ex_long  in  1  EX valid, writes rd, result not yet available (load or MDU issue).
- ex_rd  in  RW; ex_res  in  XLEN.
- mem_valid, mem_wen  in  1; mem_rd  in  RW; mem_res  in  XLEN.
- wb_valid, wb_wen  in  1; wb_rd  in  RW; wb_res  in  XLEN.
- mdu_issue  in  1  EX hands an op to the MDU this cycle (rd = ex_rd).
- mdu_done  in  1; mdu_rd  in  RW; mdu_res  in  XLEN  MDU writeback.
- op1_fwd, op2_fwd  out  XLEN  forwarded operands.
- stall  out  1  hold IF/ID, inject bubble into EX.
- sb_pending  out  NREG  scoreboard bits (bit 0 always 0).

## Operation
- Per-source match from stage S: S_valid & S_wen & S_rd == rs & rs != 0 & use_rs.
- Operand priority: EX (only if !ex_long) > MEM > MDU done (mdu_done & mdu_rd == rs) > WB > id_opN.
- When use_rs = 0, output is id_opN unchanged. This is the immediate path.
- Hazard for a source (only when use_rs and rs != 0):
  - EX match with ex_long = 1, or
  - sb_pending[rs] = 1 and not (mdu_done & mdu_rd == rs).
- stall = id_valid & (hazard on rs1 | hazard on rs2).
- Scoreboard update on each clk edge:
  - Set bit ex_rd when mdu_issue & ex_valid & ex_rd != 0.
  - Clear bit mdu_rd when mdu_done.
  - Same index set and cleared in one cycle: set wins, so the new issue stays pending.
- Bit 0 is never set.
- mdu_done for a non-pending index: no scoreboard effect; forwarding still applies.

## Timing
- op1_fwd, op2_fwd and stall are combinational from inputs and the registered scoreboard; zero-cycle latency.
- sb_pending changes one cycle after issue or done. A consumer in ID during the issue cycle is caught by the EX ex_long match instead.
- Reset values: sb_pending = 0. Combinational outputs follow their inputs, so with all valids low, stall = 0 and opN_fwd = id_opN.
- Reset asserted mid-operation clears all pending bits immediately. MDU results arriving after reset still forward but leave no scoreboard state.

## Configuration
- HAZARD_PERF_EN defined: adds output stall_cnt [31:0] and output sb_busy_cnt [31:0].
  - stall_cnt increments on every cycle with stall = 1.
  - sb_busy_cnt increments on every cycle with any sb_pending bit set.
  - Both wrap at 2^32 and reset to 0 asynchronously.
- HAZARD_PERF_EN undefined: neither port nor counter exists; all other behaviour is identical.

## Structure
- Shared package holds:
  - the stage-ID enum used for forwarding select: FWD_ID, FWD_EX, FWD_MEM, FWD_MDU, FWD_WB;
  - default XLEN and NREG constants.
- Sub-module fwd_select: one per source, instantiated twice. Inputs are rs, use_rs, the stage matches and results. Outputs are the operand and the per-source hazard.
- Scoreboard and counters live in the top module.

## Test plan
- Reset release, all valids low, id_op1 = 0x11 -> op1_fwd = 0x11, stall = 0, sb_pending = 0.
- EX, MEM and WB all write x5 with ex_res = 0xA, mem_res = 0xB, wb_res = 0xC; id_rs1 = 5 -> op1_fwd = 0xA. Drop EX -> 0xB. Drop MEM -> 0xC.
- All stages write x0 = 0xFF; id_rs2 = 0, id_op2 = 0 -> op2_fwd = 0, stall = 0. Repeat with id_use_rs2 = 0 and id_rs2 = 5 while EX writes x5 -> op2_fwd = id_op2.
- Load in EX to x7 (ex_long = 1); ID reads x7 -> stall = 1. Next cycle load in MEM with mem_res = 0x99 -> stall = 0, op1_fwd = 0x99.
- mdu_issue to x9; ID reads x9 for 3 cycles -> stall = 1 and sb_pending[9] = 1. mdu_done with mdu_rd = 9, mdu_res = 0x1234 -> stall = 0 in the same cycle, op_fwd = 0x1234, bit cleared next edge. Same-cycle issue and done to x9 -> bit stays set.
- Assert rst with sb_pending[3] set -> bit clears without a clock edge. With HAZARD_PERF_EN, stall_cnt returns to 0 and counts exactly the stall cycles of the MDU case.
